playback_controller: RTL and testbench

Sequencer for the flash-to-I2S audio pipeline. Owns power-up delay, track selection, header parsing, end-of-track detection and pause/next control. It drives the SPI flash reader's start/address/abort, gates SPI byte strobes into the byte assembler, clears the pipeline between tracks and enables the I2S transmitter's FIFO reads. Replaces the ad-hoc start timer and fixed start address at top level.

---
 rtl/playback_pkg.sv | 32 +++
 rtl/track_header_parser.sv | 48 ++++
 rtl/playback_controller.sv | 170 +++++++++++++++++
 tb/tb_playback_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer: state encoding, widths and
// helpers for track-slot addressing.
package playback_pkg;

  localparam int ADDR_W    = 24;
  localparam int HDR_BYTES = 3;

  typedef logic [3:0] state_t;

  localparam state_t S_BOOT   = 4'd0;
  localparam state_t S_IDLE   = 4'd1;
  localparam state_t S_LOAD   = 4'd2;
  localparam state_t S_START  = 4'd3;
  localparam state_t S_HDR    = 4'd4;
  localparam state_t S_PLAY   = 4'd5;
  localparam state_t S_PAUSED = 4'd6;
  localparam state_t S_DRAIN  = 4'd7;
  localparam state_t S_END    = 4'd8;

  // Track number after idx, wrapping from the last slot back to 0.
  function automatic logic [3:0] next_track(input logic [3:0] idx,
                                            input int unsigned num_tracks);
    return ({28'd0, idx} >= num_tracks - 32'd1) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] stride,
                                                  input logic [3:0]        idx);
    return base + stride * {20'd0, idx};
  endfunction

endpackage

// File: rtl/track_header_parser.sv
// Captures the 3-byte big-endian track length header and applies the
// clamp / even-length rules; o_done fires combinationally on the last byte.
module track_header_parser
  import playback_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLOT_BYTES = 24'h080000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic              o_done,
  output logic              o_zero,
  output logic [ADDR_W-1:0] o_len
);

  localparam logic [ADDR_W-1:0] MAX_LEN  = SLOT_BYTES - 24'd3;
  localparam logic [1:0]        LAST_IDX = 2'(HDR_BYTES - 1);

  logic [1:0]        r_cnt;
  logic [15:0]       r_hi;
  logic [ADDR_W-1:0] w_raw;
  logic [ADDR_W-1:0] w_clamped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_hi  <= 16'd0;
    end else if (i_clear) begin
      r_cnt <= 2'd0;
      r_hi  <= 16'd0;
    end else if (i_enable && i_valid && (r_cnt != LAST_IDX)) begin
      r_hi  <= {r_hi[7:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // The final byte is used straight off the bus so the top can enter PLAY
  // before the first payload byte can possibly arrive.
  assign w_raw     = {r_hi, i_byte};
  assign w_clamped = (w_raw > MAX_LEN) ? MAX_LEN : w_raw;
  assign o_len     = {w_clamped[ADDR_W-1:1], 1'b0};
  assign o_done    = i_enable & i_valid & (r_cnt == LAST_IDX);
  assign o_zero    = (o_len == '0);

endmodule

// File: rtl/playback_controller.sv
// Flash-to-I2S playback sequencer: boot delay, track selection, header
// parsing, end-of-track detection, pause and skip control.
module playback_controller
  import playback_pkg::*;
#(
  parameter int unsigned       BOOT_CYCLES = 1000000,
  parameter int unsigned       NUM_TRACKS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h200000,
  parameter logic [ADDR_W-1:0] SLOT_BYTES  = 24'h080000,
  parameter bit                AUTOPLAY    = 1'b1,
  parameter bit                LOOP_ALL    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_play,
  input  logic              btn_next,
  input  logic              spi_valid,
  input  logic [7:0]        spi_byte,
  input  logic              fifo_empty,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_abort,
  output logic              asm_valid,
  output logic              pipe_clr,
  output logic              play_en,
  output logic [3:0]        track_idx,
  output logic              led_running
);

  state_t            r_state;
  logic [31:0]       r_boot_cnt;
  logic [3:0]        r_track;
  logic              r_rd_start;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_abort;
  logic              r_pipe_clr;
  logic [ADDR_W-1:0] r_byte_cnt;
  logic [ADDR_W-1:0] r_len;
  logic              r_ended;
  logic              r_empty_seen;

  logic              w_streaming;
  logic              w_last;
  logic              w_skip;
  logic              w_hdr_done;
  logic              w_hdr_zero;
  logic [ADDR_W-1:0] w_hdr_len;

  track_header_parser #(
    .SLOT_BYTES (SLOT_BYTES)
  ) u_parser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state == S_LOAD),
    .i_enable (r_state == S_HDR),
    .i_valid  (spi_valid),
    .i_byte   (spi_byte),
    .o_done   (w_hdr_done),
    .o_zero   (w_hdr_zero),
    .o_len    (w_hdr_len)
  );

  // Once the end is reached while paused, late reader bytes are dropped.
  assign w_streaming = (r_state == S_PLAY) || ((r_state == S_PAUSED) && !r_ended);
  assign asm_valid   = spi_valid & w_streaming;
  assign w_last      = asm_valid && ((r_byte_cnt + 24'd1) == r_len);
  assign w_skip      = btn_next && ((r_state == S_HDR) || (r_state == S_PLAY) ||
                                    (r_state == S_PAUSED) || (r_state == S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_boot_cnt   <= 32'd0;
      r_track      <= 4'd0;
      r_rd_start   <= 1'b0;
      r_rd_addr    <= BASE_ADDR;
      r_rd_abort   <= 1'b1;
      r_pipe_clr   <= 1'b0;
      r_byte_cnt   <= '0;
      r_len        <= '0;
      r_ended      <= 1'b0;
      r_empty_seen <= 1'b0;
    end else begin
      r_rd_start <= 1'b0;
      r_pipe_clr <= 1'b0;
      if (r_state != S_DRAIN) r_empty_seen <= 1'b0;
      if (asm_valid) r_byte_cnt <= r_byte_cnt + 24'd1;

      if (w_skip) begin
        r_rd_abort <= 1'b1;
        r_track    <= next_track(r_track, NUM_TRACKS);
        r_state    <= S_LOAD;
      end else begin
        case (r_state)
          S_BOOT: begin
            if (r_boot_cnt == BOOT_CYCLES - 32'd1) r_state <= AUTOPLAY ? S_LOAD : S_IDLE;
            else r_boot_cnt <= r_boot_cnt + 32'd1;
          end
          S_IDLE: begin
            r_rd_abort <= 1'b1;
            if (btn_next) r_track <= next_track(r_track, NUM_TRACKS);
            else if (btn_play) r_state <= S_LOAD;
          end
          S_LOAD: begin
            r_pipe_clr <= 1'b1;
            r_rd_abort <= 1'b0;
            r_rd_addr  <= slot_addr(BASE_ADDR, SLOT_BYTES, r_track);
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_ended    <= 1'b0;
            r_state    <= S_START;
          end
          S_START: begin
            r_rd_start <= 1'b1;
            r_state    <= S_HDR;
          end
          S_HDR: begin
            if (w_hdr_done) begin
              if (w_hdr_zero) begin
                r_rd_abort <= 1'b1;
                r_state    <= S_END;
              end else begin
                r_len   <= w_hdr_len;
                r_state <= S_PLAY;
              end
            end
          end
          S_PLAY: begin
            if (w_last) begin
              r_rd_abort <= 1'b1;
              r_state    <= S_DRAIN;
            end else if (btn_play) begin
              r_state <= S_PAUSED;
            end
          end
          S_PAUSED: begin
            if (w_last) begin
              r_rd_abort <= 1'b1;
              r_ended    <= 1'b1;
            end
            if (btn_play) r_state <= (r_ended || w_last) ? S_DRAIN : S_PLAY;
          end
          S_DRAIN: begin
            if (fifo_empty) begin
              if (r_empty_seen) r_state <= S_END;
              else r_empty_seen <= 1'b1;
            end else begin
              r_empty_seen <= 1'b0;
            end
          end
          S_END: begin
            r_rd_abort <= 1'b1;
            r_track    <= next_track(r_track, NUM_TRACKS);
            r_state    <= LOOP_ALL ? S_LOAD : S_IDLE;
          end
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

  assign rd_start    = r_rd_start;
  assign rd_addr     = r_rd_addr;
  assign rd_abort    = r_rd_abort;
  assign pipe_clr    = r_pipe_clr;
  assign play_en     = (r_state == S_PLAY) || (r_state == S_DRAIN);
  assign led_running = (r_state == S_PLAY);
  assign track_idx   = r_track;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller; expected track starts are queued
// as stimulus is applied and checked when rd_start fires.
module tb_playback_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_play = 1'b0;
  logic        btn_next = 1'b0;
  logic        spi_valid = 1'b0;
  logic [7:0]  spi_byte = 8'd0;
  logic        fifo_empty = 1'b0;
  logic        rd_start;
  logic [23:0] rd_addr;
  logic        rd_abort;
  logic        asm_valid;
  logic        pipe_clr;
  logic        play_en;
  logic [3:0]  track_idx;
  logic        led_running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] addr;
    logic [3:0]  trk;
  } start_t;
  start_t exp_q[$];
  start_t mon_e;

  playback_controller #(
    .BOOT_CYCLES (100),
    .NUM_TRACKS  (4),
    .BASE_ADDR   (24'h200000),
    .SLOT_BYTES  (24'h080000),
    .AUTOPLAY    (1'b1),
    .LOOP_ALL    (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_play    (btn_play),
    .btn_next    (btn_next),
    .spi_valid   (spi_valid),
    .spi_byte    (spi_byte),
    .fifo_empty  (fifo_empty),
    .rd_start    (rd_start),
    .rd_addr     (rd_addr),
    .rd_abort    (rd_abort),
    .asm_valid   (asm_valid),
    .pipe_clr    (pipe_clr),
    .play_en     (play_en),
    .track_idx   (track_idx),
    .led_running (led_running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rd_start must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rd_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_start observed addr %h expected no start", rd_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_addr", {8'd0, rd_addr}, {8'd0, mon_e.addr});
        check("start_track", {28'd0, track_idx}, {28'd0, mon_e.trk});
        $display("start addr=%h track=%0d", rd_addr, track_idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_fwd, input string tag);
    @(negedge clk);
    spi_valid = 1'b1;
    spi_byte  = b;
    #1;
    check(tag, {31'd0, asm_valid}, {31'd0, exp_fwd});
    @(posedge clk);
    #1;
    spi_valid = 1'b0;
  endtask

  task automatic pulse(input logic play, input logic nxt);
    @(negedge clk);
    btn_play = play;
    btn_next = nxt;
    @(posedge clk);
    #1;
    btn_play = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (rd_start === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s observed no rd_start expected one within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    // Reset values, with a strobe present to prove gating.
    spi_valid = 1'b1;
    #23;
    check("rst_rd_start", {31'd0, rd_start}, 32'd0);
    check("rst_rd_addr", {8'd0, rd_addr}, 32'h200000);
    check("rst_rd_abort", {31'd0, rd_abort}, 32'd1);
    check("rst_asm_valid", {31'd0, asm_valid}, 32'd0);
    check("rst_play_en", {31'd0, play_en}, 32'd0);
    check("rst_track", {28'd0, track_idx}, 32'd0);
    spi_valid = 1'b0;

    // Boot: pipe_clr at edge 101, rd_start at edge 102.
    exp_q.push_back('{24'h200000, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 102; i++) begin
      tick();
      if (i == 100) check("boot_no_clr_early", {31'd0, pipe_clr}, 32'd0);
      if (i == 101) begin
        check("boot_pipe_clr", {31'd0, pipe_clr}, 32'd1);
        check("boot_no_start_early", {31'd0, rd_start}, 32'd0);
      end
    end
    check("boot_start", {31'd0, rd_start}, 32'd1);
    check("boot_abort_released", {31'd0, rd_abort}, 32'd0);

    // Track 0: length 10, 12 bytes delivered.
    send_byte(8'h00, 1'b0, "hdr0_b0");
    send_byte(8'h00, 1'b0, "hdr0_b1");
    send_byte(8'h0A, 1'b0, "hdr0_b2");
    check("play0_play_en", {31'd0, play_en}, 32'd1);
    check("play0_led", {31'd0, led_running}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(i), (i < 10), "fwd0");
      if (i == 9) check("abort_after_last", {31'd0, rd_abort}, 32'd1);
    end
    check("drain_play_en", {31'd0, play_en}, 32'd1);
    check("drain_led", {31'd0, led_running}, 32'd0);
    tick();
    tick();
    tick();
    check("drain_waits_fifo", {31'd0, play_en}, 32'd1);
    exp_q.push_back('{24'h280000, 4'd1});
    @(negedge clk);
    fifo_empty = 1'b1;
    wait_start("start_track1", 20);
    fifo_empty = 1'b0;

    // Track 1: length 7 -> 6, paused mid-track, counting continues.
    send_byte(8'h00, 1'b0, "hdr1_b0");
    send_byte(8'h00, 1'b0, "hdr1_b1");
    send_byte(8'h07, 1'b0, "hdr1_b2");
    send_byte(8'h11, 1'b1, "fwd1");
    send_byte(8'h12, 1'b1, "fwd1");
    pulse(1'b1, 1'b0);
    check("pause_play_en", {31'd0, play_en}, 32'd0);
    check("pause_led", {31'd0, led_running}, 32'd0);
    send_byte(8'h13, 1'b1, "fwd1_paused");
    send_byte(8'h14, 1'b1, "fwd1_paused");
    pulse(1'b1, 1'b0);
    check("resume_play_en", {31'd0, play_en}, 32'd1);
    check("resume_led", {31'd0, led_running}, 32'd1);
    send_byte(8'h15, 1'b1, "fwd1");
    send_byte(8'h16, 1'b1, "fwd1");
    check("abort_after_odd_len", {31'd0, rd_abort}, 32'd1);
    send_byte(8'h17, 1'b0, "fwd1_after_end");
    exp_q.push_back('{24'h300000, 4'd2});
    @(negedge clk);
    fifo_empty = 1'b1;
    wait_start("start_track2", 20);
    fifo_empty = 1'b0;

    // Track 2: oversize header clamps to an even length; next+play together.
    send_byte(8'hFF, 1'b0, "hdr2_b0");
    send_byte(8'hFF, 1'b0, "hdr2_b1");
    send_byte(8'hFF, 1'b0, "hdr2_b2");
    check("clamp_len", {8'd0, dut.r_len}, 32'h07FFFC);
    send_byte(8'h21, 1'b1, "fwd2");
    send_byte(8'h22, 1'b1, "fwd2");
    exp_q.push_back('{24'h380000, 4'd3});
    pulse(1'b1, 1'b1);
    check("next_track", {28'd0, track_idx}, 32'd3);
    check("next_play_en", {31'd0, play_en}, 32'd0);
    check("next_abort", {31'd0, rd_abort}, 32'd1);
    tick();
    check("next_pipe_clr", {31'd0, pipe_clr}, 32'd1);
    wait_start("start_track3", 5);

    // Track 3: empty header ends at once and wraps to track 0.
    exp_q.push_back('{24'h200000, 4'd0});
    send_byte(8'h00, 1'b0, "hdr3_b0");
    send_byte(8'h00, 1'b0, "hdr3_b1");
    send_byte(8'h00, 1'b0, "hdr3_b2");
    check("zero_len_abort", {31'd0, rd_abort}, 32'd1);
    wait_start("start_wrap0", 10);

    // Skip from HDR, then async reset in the middle of track 1.
    exp_q.push_back('{24'h280000, 4'd1});
    pulse(1'b0, 1'b1);
    wait_start("start_skip_hdr", 10);
    send_byte(8'h00, 1'b0, "hdr4_b0");
    send_byte(8'h00, 1'b0, "hdr4_b1");
    send_byte(8'h0A, 1'b0, "hdr4_b2");
    send_byte(8'h31, 1'b1, "fwd4");
    check("pre_reset_led", {31'd0, led_running}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    spi_valid = 1'b1;
    #1;
    check("async_asm_valid", {31'd0, asm_valid}, 32'd0);
    check("async_play_en", {31'd0, play_en}, 32'd0);
    check("async_led", {31'd0, led_running}, 32'd0);
    check("async_abort", {31'd0, rd_abort}, 32'd1);
    check("async_addr", {8'd0, rd_addr}, 32'h200000);
    check("async_track", {28'd0, track_idx}, 32'd0);
    spi_valid = 1'b0;
    exp_q.push_back('{24'h200000, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    wait_start("reboot_start", 150);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
